// File: rtl/alu_pkg.sv
// Shared definitions for the alu_seq stage: opcodes, default widths, FSM states.
// ALU_FAST_SHIFT_EN (see alu_seq) selects a barrel shifter instead of the iterative one.
package alu_pkg;

  localparam int unsigned ALU_WIDTH_DEF = 32;
  localparam int unsigned ALU_SHW_DEF   = 5;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_COMP = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_SHLL = 4'd4;
  localparam logic [3:0] ALU_SHRL = 4'd5;
  localparam logic [3:0] ALU_SHRA = 4'd6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_t;

  function automatic logic alu_is_shift(input logic [3:0] op);
    return (op == ALU_SHLL) || (op == ALU_SHRL) || (op == ALU_SHRA);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational shifter for alu_seq: one-bit step by default, n-bit barrel shifter
// with carry-out when ALU_FAST_SHIFT_EN is defined.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH_DEF
`ifdef ALU_FAST_SHIFT_EN
 ,parameter int unsigned SHW   = ALU_SHW_DEF
`endif
) (
  input  logic [WIDTH-1:0] din,
`ifdef ALU_FAST_SHIFT_EN
  input  logic [SHW-1:0]   amt,
`endif
  input  logic             shift_left,
  input  logic             shift_arith,
  output logic [WIDTH-1:0] dout,
  output logic             cout
);

`ifdef ALU_FAST_SHIFT_EN
  logic [WIDTH:0]        ext_l;
  logic [WIDTH:0]        ext_rl;
  logic signed [WIDTH:0] ext_ra;

  // A guard bit beside the operand catches the last bit shifted out; it stays 0 for amt=0.
  always_comb begin
    ext_l  = {1'b0, din} << amt;
    ext_rl = {din, 1'b0} >> amt;
    ext_ra = $signed({din, 1'b0}) >>> amt;
    if (shift_left) begin
      dout = ext_l[WIDTH-1:0];
      cout = ext_l[WIDTH];
    end else if (shift_arith) begin
      dout = ext_ra[WIDTH:1];
      cout = ext_ra[0];
    end else begin
      dout = ext_rl[WIDTH:1];
      cout = ext_rl[0];
    end
  end
`else
  always_comb begin
    if (shift_left) begin
      dout = {din[WIDTH-2:0], 1'b0};
      cout = din[WIDTH-1];
    end else begin
      dout = {shift_arith & din[WIDTH-1], din[WIDTH-1:1]};
      cout = din[0];
    end
  end
`endif

endmodule

// File: rtl/alu_seq.sv
// Registered ALU stage with start/ready handshake and C/Z/S/V flags.
// Shifts iterate one bit per cycle unless ALU_FAST_SHIFT_EN is defined.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH_DEF,
  parameter int unsigned SHW   = ALU_SHW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] ALU_inp1,
  input  logic [WIDTH-1:0] ALU_inp2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_s,
  output logic             flag_v
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] result_d, result_q;
  logic             c_d, c_q, z_d, z_q, s_d, s_q, v_d, v_q;
  logic             done_d, done_q;
  logic             upd_zs;
  logic             accept;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] neg_b;
  logic [WIDTH-1:0] sh_dout;
  logic             sh_cout;

  assign shamt = ALU_inp2[SHW-1:0];
  assign sum   = {1'b0, ALU_inp1} + {1'b0, ALU_inp2};
  assign neg_b = ~ALU_inp2 + {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef ALU_FAST_SHIFT_EN
  assign ready = 1'b1;

  alu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .din         (ALU_inp1),
    .amt         (shamt),
    .shift_left  (alu_op == ALU_SHLL),
    .shift_arith (alu_op == ALU_SHRA),
    .dout        (sh_dout),
    .cout        (sh_cout)
  );
`else
  alu_state_t       state_d, state_q;
  logic [WIDTH-1:0] work_d, work_q;
  logic [SHW-1:0]   cnt_d, cnt_q;
  logic             left_d, left_q;
  logic             arith_d, arith_q;

  assign ready = (state_q == ST_IDLE);

  alu_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .din         (work_q),
    .shift_left  (left_q),
    .shift_arith (arith_q),
    .dout        (sh_dout),
    .cout        (sh_cout)
  );
`endif

  assign accept = start & ready;

  always_comb begin
    result_d = result_q;
    c_d      = c_q;
    z_d      = z_q;
    s_d      = s_q;
    v_d      = v_q;
    done_d   = 1'b0;
    upd_zs   = 1'b0;
`ifndef ALU_FAST_SHIFT_EN
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    arith_d  = arith_q;
`endif

    if (accept) begin
      case (alu_op)
        ALU_ADD: begin
          result_d = sum[WIDTH-1:0];
          c_d      = sum[WIDTH];
          v_d      = (ALU_inp1[WIDTH-1] == ALU_inp2[WIDTH-1]) &&
                     (sum[WIDTH-1] != ALU_inp1[WIDTH-1]);
          done_d   = 1'b1;
          upd_zs   = 1'b1;
        end
        ALU_COMP: begin
          result_d = neg_b;
          c_d      = (ALU_inp2 == '0);
          v_d      = (ALU_inp2 == MIN_NEG);
          done_d   = 1'b1;
          upd_zs   = 1'b1;
        end
        ALU_AND: begin
          result_d = ALU_inp1 & ALU_inp2;
          done_d   = 1'b1;
          upd_zs   = 1'b1;
        end
        ALU_XOR: begin
          result_d = ALU_inp1 ^ ALU_inp2;
          done_d   = 1'b1;
          upd_zs   = 1'b1;
        end
        ALU_SHLL, ALU_SHRL, ALU_SHRA: begin
`ifdef ALU_FAST_SHIFT_EN
          result_d = sh_dout;
          c_d      = sh_cout;
          done_d   = 1'b1;
          upd_zs   = 1'b1;
`else
          if (shamt == '0) begin
            result_d = ALU_inp1;
            c_d      = 1'b0;
            done_d   = 1'b1;
            upd_zs   = 1'b1;
          end else begin
            work_d  = ALU_inp1;
            cnt_d   = shamt;
            left_d  = (alu_op == ALU_SHLL);
            arith_d = (alu_op == ALU_SHRA);
            state_d = ST_SHIFT;
          end
`endif
        end
        default: begin
          result_d = '0;
          done_d   = 1'b1;
        end
      endcase
    end

`ifndef ALU_FAST_SHIFT_EN
    // The final step's output goes straight to result so done lands on the n-th busy edge.
    if (state_q == ST_SHIFT) begin
      work_d = sh_dout;
      cnt_d  = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
      if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
        result_d = sh_dout;
        c_d      = sh_cout;
        done_d   = 1'b1;
        upd_zs   = 1'b1;
        state_d  = ST_IDLE;
      end
    end
`endif

    if (upd_zs) begin
      z_d = (result_d == '0);
      s_d = result_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      s_q      <= 1'b0;
      v_q      <= 1'b0;
      done_q   <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      state_q  <= ST_IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      arith_q  <= 1'b0;
`endif
    end else begin
      result_q <= result_d;
      c_q      <= c_d;
      z_q      <= z_d;
      s_q      <= s_d;
      v_q      <= v_d;
      done_q   <= done_d;
`ifndef ALU_FAST_SHIFT_EN
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      arith_q  <= arith_d;
`endif
    end
  end

  assign done   = done_q;
  assign result = result_q;
  assign flag_c = c_q;
  assign flag_z = z_q;
  assign flag_s = s_q;
  assign flag_v = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed cases, randomized ops against a reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned S = 5;
`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    alu_op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          ready, done, flag_c, flag_z, flag_s, flag_v;
  logic [W-1:0]  result;

  alu_seq #(.WIDTH(W), .SHW(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .alu_op   (alu_op),
    .ALU_inp1 (a),
    .ALU_inp2 (b),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .flag_s   (flag_s),
    .flag_v   (flag_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        c, z, s, v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  logic mc = 1'b0, mz = 1'b0, ms = 1'b0, mv = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
  endfunction

  // Reference model: plain arithmetic on the opcode rules, tracking architectural flags.
  task automatic model(input logic [3:0] op, input logic [31:0] A, input logic [31:0] B,
                       output exp_t e, output int lat);
    int unsigned        n;
    logic [32:0]        w33;
    longint             ssum;
    logic signed [31:0] sa;
    logic [31:0]        r;
    n  = int'(B[4:0]);
    sa = A;
    r  = '0;
    case (op)
      4'd0: begin
        w33  = {1'b0, A} + {1'b0, B};
        r    = w33[31:0];
        mc   = w33[32];
        ssum = longint'($signed(A)) + longint'($signed(B));
        mv   = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
      end
      4'd1: begin r = -B; mc = (B == 32'd0); mv = (B == 32'h8000_0000); end
      4'd2: r = A & B;
      4'd3: r = A ^ B;
      4'd4: begin r = A << n;  mc = (n == 0) ? 1'b0 : A[32-n]; end
      4'd5: begin r = A >> n;  mc = (n == 0) ? 1'b0 : A[n-1]; end
      4'd6: begin r = sa >>> n; mc = (n == 0) ? 1'b0 : A[n-1]; end
      default: r = '0;
    endcase
    if (op <= 4'd6) begin
      mz = (r == 32'd0);
      ms = r[31];
    end
    e.res = r; e.c = mc; e.z = mz; e.s = ms; e.v = mv;
    lat = (op >= 4'd4 && op <= 4'd6 && n != 0 && !FAST) ? int'(n) + 1 : 1;
  endtask

  // Monitor: pops on every done, otherwise requires result/flags to hold.
  logic [35:0] prev_out = '0;
  logic        prev_rst = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !prev_rst) begin
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", {63'd0, done}, 64'd0);
        else begin
          e = sb.pop_front();
          chk("result", {32'd0, result}, {32'd0, e.res});
          chk("flags_czsv", {60'd0, flag_c, flag_z, flag_s, flag_v}, {60'd0, e.c, e.z, e.s, e.v});
        end
      end else begin
        chk("hold", {28'd0, result, flag_c, flag_z, flag_s, flag_v}, {28'd0, prev_out});
      end
    end
    prev_out <= {result, flag_c, flag_z, flag_s, flag_v};
    prev_rst <= rst;
  end

  // Entered at a negedge; returns at the negedge where done is seen (or budget expired).
  task automatic issue(input logic [3:0] op, input logic [31:0] A, input logic [31:0] B);
    exp_t e;
    int   lat, waited, busy;
    chk("ready_at_issue", {63'd0, ready}, 64'd1);
    model(op, A, B, e, lat);
    sb.push_back(e);
    #1;
    start = 1'b1; alu_op = op; a = A; b = B;
    waited = 0; busy = 0;
    forever begin
      @(negedge clk);
      waited++;
      if (done) break;
      if (!ready) busy++;
      if (waited >= 40) break;
      #1;
      start  = (busy == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      alu_op = 4'($urandom);
      a      = $urandom;
      b      = $urandom;
    end
    chk("latency", 64'(waited), 64'(lat));
    chk("busy_cycles", 64'(busy), 64'(lat - 1));
    if (!done) sb.delete();
  endtask

  task automatic idle(input int cycles);
    #1;
    start = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic random_ops(input int count);
    logic [3:0] op;
    for (int i = 0; i < count; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      issue(op, pick(), ($urandom_range(0, 3) == 0) ? pick() : $urandom);
    end
  endtask

  initial begin
    @(negedge clk);
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_flags", {60'd0, flag_c, flag_z, flag_s, flag_v}, 64'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    issue(ALU_ADD, 32'd5, 32'd6);
    chk("plan_add", {31'd0, result, flag_c}, {31'd0, 32'd11, 1'b0});
    issue(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    chk("plan_ovf", {28'd0, result, flag_c, flag_z, flag_s, flag_v}, {28'd0, 32'h8000_0000, 4'b0011});
    issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1);
    chk("plan_carry", {28'd0, result, flag_c, flag_z, flag_s, flag_v}, {28'd0, 32'd0, 4'b1100});
    issue(ALU_SHRA, 32'h8000_0010, 32'd4);
    chk("plan_shra", {31'd0, result, flag_c}, {31'd0, 32'hF800_0001, 1'b0});
    issue(ALU_SHLL, 32'h8000_0001, 32'd0);
    chk("plan_shll0", {31'd0, result, flag_c}, {31'd0, 32'h8000_0001, 1'b0});
    issue(ALU_SHLL, 32'h8000_0001, 32'd1);
    chk("plan_shll1", {31'd0, result, flag_c}, {31'd0, 32'h0000_0002, 1'b1});
    issue(ALU_COMP, 32'd0, 32'd6);
    chk("plan_comp", {31'd0, result, flag_s}, {31'd0, 32'hFFFF_FFFA, 1'b1});
    issue(ALU_XOR, 32'h55, 32'h55);
    chk("plan_xor_z", {63'd0, flag_z}, 64'd1);
    issue(4'd9, 32'h1234, 32'h5678);
    chk("plan_illegal", {32'd0, result}, 64'd0);
    issue(ALU_COMP, 32'd0, 32'd0);
    issue(ALU_COMP, 32'd0, 32'h8000_0000);
    issue(ALU_SHRA, 32'h8000_0000, 32'd31);
    issue(ALU_SHRL, 32'hC000_0001, 32'hFFFF_FFFF);
    issue(ALU_SHLL, 32'h0000_0003, 32'd31);

    random_ops(150);

`ifndef ALU_FAST_SHIFT_EN
    begin
      int busy;
      #1;
      start = 1'b1; alu_op = ALU_SHRL; a = $urandom; b = 32'd20;
      busy = 0;
      for (int k = 0; k < 10 && busy < 5; k++) begin
        @(negedge clk);
        if (!ready) busy++;
        #1 start = 1'b0;
      end
      chk("busy_before_reset", 64'(busy), 64'd5);
      rst = 1'b1;
      @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
    end
`else
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
`endif
    chk("abort_ready", {63'd0, ready}, 64'd1);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_result", {32'd0, result}, 64'd0);
    chk("abort_flags", {60'd0, flag_c, flag_z, flag_s, flag_v}, 64'd0);
    mc = 1'b0; mz = 1'b0; ms = 1'b0; mv = 1'b0;
    idle(30);

    random_ops(30);
    idle(3);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
